alu_share_arbiter: RTL and testbench

Shares the single-cycle integer ALU between two requesters: port 0 (execute stage) and port 1 (branch/address helper). Each requester presents an ALU operation code plus two operands under a req/gnt handshake. The block picks one requester per cycle by round-robin, drives the shared ALU, and captures the result into a per-requester one-entry response buffer drained under valid/ready. It sits between the requesters and the ALU, downstream of `alu_control`, which produces the 4-bit operation codes carried on `sel*`.

---
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one single-cycle ALU between two requesters, with a one-entry
// response buffer per requester. Define ALU_ARB_PERF_EN to build the performance counters.
module alu_share_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [1:0]       req,
    input  logic [3:0]       sel0,
    input  logic [XLEN-1:0]  a0,
    input  logic [XLEN-1:0]  b0,
    input  logic [3:0]       sel1,
    input  logic [XLEN-1:0]  a1,
    input  logic [XLEN-1:0]  b1,
    output logic [1:0]       gnt,

    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [XLEN-1:0]  rsp_data0,
    output logic [XLEN-1:0]  rsp_data1,

    output logic [3:0]       alu_sel_o,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    input  logic [XLEN-1:0]  alu_y_i,
    output logic             alu_busy_o,

    output logic [CNT_W-1:0] perf_grants_o,
    output logic [CNT_W-1:0] perf_conflicts_o
);

    logic            prio_q, prio_d;
    logic [1:0]      valid_q, valid_d;
    logic [XLEN-1:0] data0_q, data0_d;
    logic [XLEN-1:0] data1_q, data1_d;
    logic [1:0]      elig;

    // A full buffer may accept a new result only in the cycle it is being drained.
    always_comb begin
        elig = 2'b00;
        if (!rst) begin
            elig[0] = req[0] & (~valid_q[0] | rsp_ready[0]);
            elig[1] = req[1] & (~valid_q[1] | rsp_ready[1]);
        end
    end

    always_comb begin
        gnt = elig;
        if (elig == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    always_comb begin
        alu_sel_o = '0;
        alu_a_o   = '0;
        alu_b_o   = '0;
        if (gnt[0]) begin
            alu_sel_o = sel0;
            alu_a_o   = a0;
            alu_b_o   = b0;
        end else if (gnt[1]) begin
            alu_sel_o = sel1;
            alu_a_o   = a1;
            alu_b_o   = b1;
        end
    end

    assign alu_busy_o = |gnt;

    always_comb begin
        valid_d = valid_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (gnt[0]) begin
            valid_d[0] = 1'b1;
            data0_d    = alu_y_i;
        end else if (rsp_ready[0]) begin
            valid_d[0] = 1'b0;
        end
        if (gnt[1]) begin
            valid_d[1] = 1'b1;
            data1_d    = alu_y_i;
        end else if (rsp_ready[1]) begin
            valid_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q  <= 1'b0;
            valid_q <= 2'b00;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            prio_q  <= prio_d;
            valid_q <= valid_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    // Data outputs come straight from registers: no path from rsp_ready.
    assign rsp_valid = valid_q;
    assign rsp_data0 = data0_q;
    assign rsp_data1 = data1_q;

`ifdef ALU_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] grants_q, grants_d;
    logic [CNT_W-1:0] conflicts_q, conflicts_d;

    always_comb begin
        grants_d    = grants_q;
        conflicts_d = conflicts_q;
        if ((|gnt) && (grants_q != '1)) begin
            grants_d = grants_q + CntOne;
        end
        if ((elig == 2'b11) && (conflicts_q != '1)) begin
            conflicts_d = conflicts_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grants_q    <= '0;
            conflicts_q <= '0;
        end else begin
            grants_q    <= grants_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign perf_grants_o    = grants_q;
    assign perf_conflicts_o = conflicts_q;
`else
    assign perf_grants_o    = '0;
    assign perf_conflicts_o = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table plus randomized traffic checked
// against a cycle-level reference model of the arbitration and buffering rules.
module tb_alu_share_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [3:0]  OpAdd = 4'h2;
    localparam int unsigned CntMax = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, rsp_ready, gnt, rsp_valid;
    logic [3:0]       sel0, sel1, alu_sel;
    logic [XLEN-1:0]  a0, b0, a1, b1, rsp_data0, rsp_data1, alu_a, alu_b, alu_y;
    logic             alu_busy;
    logic [CNT_W-1:0] perf_grants, perf_conflicts;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_fn(logic [3:0] s, logic [XLEN-1:0] x,
                                               logic [XLEN-1:0] y);
        case (s)
            4'h0:    return x & y;
            4'h1:    return x | y;
            4'h2:    return x + y;
            4'h6:    return x - y;
            4'h7:    return ($signed(x) < $signed(y)) ? 1 : 0;
            4'hc:    return ~(x | y);
            default: return x ^ y;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_sel, alu_a, alu_b);

    alu_share_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .sel0             (sel0),
        .a0               (a0),
        .b0               (b0),
        .sel1             (sel1),
        .a1               (a1),
        .b1               (b1),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data0        (rsp_data0),
        .rsp_data1        (rsp_data1),
        .alu_sel_o        (alu_sel),
        .alu_a_o          (alu_a),
        .alu_b_o          (alu_b),
        .alu_y_i          (alu_y),
        .alu_busy_o       (alu_busy),
        .perf_grants_o    (perf_grants),
        .perf_conflicts_o (perf_conflicts)
    );

    // Reference model state
    bit          m_prio;
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int unsigned m_grants, m_conf;
    logic [1:0]  obs_gnt;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        bit          e[2];
        int          win;
        logic [31:0] y;
        for (int i = 0; i < 2; i++)
            e[i] = !rst && req[i] && (!m_valid[i] || rsp_ready[i]);
        if (e[0] && e[1])  win = m_prio ? 1 : 0;
        else if (e[0])     win = 0;
        else if (e[1])     win = 1;
        else               win = -1;
        y = (win == 0) ? alu_fn(sel0, a0, b0) : alu_fn(sel1, a1, b1);
        #1;
        chk("gnt", 32'(gnt), (win < 0) ? 32'd0 : 32'(1 << win));
        chk("alu_busy", 32'(alu_busy), 32'(win >= 0));
        chk("alu_sel", 32'(alu_sel), (win == 0) ? 32'(sel0) : (win == 1) ? 32'(sel1) : 32'd0);
        chk("alu_a", alu_a, (win == 0) ? a0 : (win == 1) ? a1 : 32'd0);
        chk("alu_b", alu_b, (win == 0) ? b0 : (win == 1) ? b1 : 32'd0);
        obs_gnt = gnt;
        @(posedge clk);
        if (rst) begin
            m_prio = 0;
            m_valid = '{0, 0};
            m_data = '{32'd0, 32'd0};
            m_grants = 0;
            m_conf = 0;
        end else begin
            if (win >= 0) begin
                m_prio = (win == 0);
                if (m_grants < CntMax) m_grants++;
            end
            if (e[0] && e[1] && m_conf < CntMax) m_conf++;
            for (int i = 0; i < 2; i++) begin
                if (win == i) begin
                    m_valid[i] = 1;
                    m_data[i] = y;
                end else if (rsp_ready[i]) begin
                    m_valid[i] = 0;
                end
            end
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), {30'd0, m_valid[1], m_valid[0]});
        chk("rsp_data0", rsp_data0, m_data[0]);
        chk("rsp_data1", rsp_data1, m_data[1]);
`ifdef ALU_ARB_PERF_EN
        chk("perf_grants", 32'(perf_grants), m_grants);
        chk("perf_conflicts", 32'(perf_conflicts), m_conf);
`else
        chk("perf_grants", 32'(perf_grants), 32'd0);
        chk("perf_conflicts", 32'(perf_conflicts), 32'd0);
`endif
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        r;
        logic [1:0]  rq;
        logic [1:0]  rdy;
        logic [31:0] xa0, xb0, xa1, xb1;
        logic [1:0]  g;
        logic [1:0]  v;
        logic [31:0] d0, d1;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] rq, logic [1:0] rdy,
                                logic [31:0] xa0, logic [31:0] xb0,
                                logic [31:0] xa1, logic [31:0] xb1,
                                logic [1:0] g, logic [1:0] v,
                                logic [31:0] d0, logic [31:0] d1);
        return '{r: r, rq: rq, rdy: rdy, xa0: xa0, xb0: xb0, xa1: xa1, xb1: xb1,
                 g: g, v: v, d0: d0, d1: d1};
    endfunction

    vec_t tbl[18];

    initial begin
        // rst  req    rdy    a0 b0   a1       b1     gnt    valid  d0  d1
        tbl[0]  = mk(0, 2'b01, 2'b00, 5, 7,   0,       0,     2'b01, 2'b01, 12, 0);
        tbl[1]  = mk(0, 2'b00, 2'b01, 5, 7,   0,       0,     2'b00, 2'b00, 12, 0);
        tbl[2]  = mk(1, 2'b11, 2'b00, 5, 7,   0,       0,     2'b00, 2'b00, 0,  0);
        tbl[3]  = mk(0, 2'b11, 2'b11, 1, 2,   10,      20,    2'b01, 2'b01, 3,  0);
        tbl[4]  = mk(0, 2'b11, 2'b11, 3, 4,   10,      20,    2'b10, 2'b10, 3,  30);
        tbl[5]  = mk(0, 2'b11, 2'b11, 3, 4,   100,     1,     2'b01, 2'b01, 7,  30);
        tbl[6]  = mk(0, 2'b11, 2'b11, 5, 5,   100,     1,     2'b10, 2'b10, 7,  101);
        tbl[7]  = mk(0, 2'b01, 2'b00, 8, 8,   0,       0,     2'b01, 2'b11, 16, 101);
        tbl[8]  = mk(0, 2'b01, 2'b00, 9, 9,   0,       0,     2'b00, 2'b11, 16, 101);
        tbl[9]  = mk(0, 2'b01, 2'b01, 9, 9,   0,       0,     2'b01, 2'b11, 18, 101);
        tbl[10] = mk(0, 2'b01, 2'b01, 1, 1,   0,       0,     2'b01, 2'b11, 2,  101);
        tbl[11] = mk(0, 2'b01, 2'b01, 2, 2,   0,       0,     2'b01, 2'b11, 4,  101);
        tbl[12] = mk(0, 2'b01, 2'b01, 3, 3,   0,       0,     2'b01, 2'b11, 6,  101);
        tbl[13] = mk(0, 2'b01, 2'b01, 4, 4,   0,       0,     2'b01, 2'b11, 8,  101);
        tbl[14] = mk(0, 2'b10, 2'b10, 0, 0,   'hde00,  'had,  2'b10, 2'b11, 8,  'hdead);
        tbl[15] = mk(0, 2'b01, 2'b01, 5, 5,   0,       0,     2'b01, 2'b11, 10, 'hdead);
        tbl[16] = mk(1, 2'b11, 2'b00, 1, 1,   2,       2,     2'b00, 2'b00, 0,  0);
        tbl[17] = mk(0, 2'b11, 2'b00, 1, 1,   2,       2,     2'b01, 2'b01, 2,  0);

        rst = 1'b1;
        req = 2'b00;
        rsp_ready = 2'b00;
        sel0 = OpAdd;
        sel1 = OpAdd;
        {a0, b0, a1, b1} = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        for (int k = 0; k < 18; k++) begin
            rst = tbl[k].r;
            req = tbl[k].rq;
            rsp_ready = tbl[k].rdy;
            sel0 = OpAdd;
            sel1 = OpAdd;
            a0 = tbl[k].xa0;
            b0 = tbl[k].xb0;
            a1 = tbl[k].xa1;
            b1 = tbl[k].xb1;
            step();
            chk($sformatf("tbl%0d.gnt", k), 32'(obs_gnt), 32'(tbl[k].g));
            chk($sformatf("tbl%0d.valid", k), 32'(rsp_valid), 32'(tbl[k].v));
            chk($sformatf("tbl%0d.d0", k), rsp_data0, tbl[k].d0);
            chk($sformatf("tbl%0d.d1", k), rsp_data1, tbl[k].d1);
        end

        // Perf scenario: 3 contention cycles then 2 single-request cycles after reset.
        rst = 1'b1;
        req = 2'b11;
        step();
        rst = 1'b0;
        rsp_ready = 2'b11;
        repeat (3) step();
        req = 2'b01;
        repeat (2) step();
`ifdef ALU_ARB_PERF_EN
        chk("perf5_grants", 32'(perf_grants), 32'd5);
        chk("perf5_conflicts", 32'(perf_conflicts), 32'd3);
`endif
        // 20 more single grants drive the narrow grant counter into saturation.
        repeat (20) step();
`ifdef ALU_ARB_PERF_EN
        chk("perf_sat", 32'(perf_grants), 32'(CntMax));
`endif

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            req = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            sel0 = 4'($urandom_range(0, 15));
            sel1 = 4'($urandom_range(0, 15));
            a0 = $urandom;
            b0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 9));
            a1 = $urandom;
            b1 = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
